// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, LSB first, valid/ready on both sides
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] D,
  output logic         b_out,
  output logic         zero,
  output logic         ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_last;

  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_d;
  logic            r_br;
  logic [CW-1:0]   r_cnt;
  logic            r_a_msb;
  logic            r_b_msb;
  logic            r_b_out;
  logic            r_zero;
  logic            r_ovf;

  logic            w_bit_a;
  logic            w_bit_b;
  logic            w_bit_d;
  logic            w_br_nxt;
  logic [N-1:0]    w_d_nxt;

  // One full-subtractor cell fed from the LSBs of the shifting operands
  always_comb begin
    w_bit_a  = r_a[0];
    w_bit_b  = r_b[0];
    w_bit_d  = w_bit_a ^ w_bit_b ^ r_br;
    w_br_nxt = (~w_bit_a & w_bit_b) | (~(w_bit_a ^ w_bit_b) & r_br);
    w_d_nxt  = {w_bit_d, r_d[N-1:1]};
    w_last   = (r_cnt == LAST_BIT);
  end

  // Next-state and handshake decode; ready/valid depend only on state (and rst)
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, serial shift and result flag latching
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_b_out <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_br    <= b_in;
      r_cnt   <= '0;
      r_a_msb <= A[N-1];
      r_b_msb <= B[N-1];
    end else if (r_state == S_RUN) begin
      r_a  <= {1'b0, r_a[N-1:1]};
      r_b  <= {1'b0, r_b[N-1:1]};
      r_d  <= w_d_nxt;
      r_br <= w_br_nxt;
      if (w_last) begin
        r_cnt   <= '0;
        r_b_out <= w_br_nxt;
        r_zero  <= (w_d_nxt == '0);
        r_ovf   <= (r_a_msb != r_b_msb) && (w_bit_d != r_a_msb);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign D     = r_d;
  assign b_out = r_b_out;
  assign zero  = r_zero;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] D;
  logic         b_out;
  logic         zero;
  logic         ovf;

  int n_vec;
  int n_err;

  serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .b_out     (b_out),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, flags from their arithmetic definitions
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       output logic [N-1:0] d, output logic bo, output logic z, output logic ov);
    int diff;
    diff = int'(a) - int'(b) - int'(bin);
    d    = N'(diff & ((1 << N) - 1));
    bo   = (diff < 0);
    z    = (d == '0);
    ov   = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    A        = a;
    B        = b;
    b_in     = bin;
    in_valid = 1'b1;
  endtask

  // Waits for the accept edge, then scrambles the inputs to prove they are not resampled
  task automatic accept();
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A        = N'($urandom);
    B        = N'($urandom);
    b_in     = 1'($urandom);
  endtask

  task automatic collect(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                         input int stall, input logic hold_next);
    logic [N-1:0] ed;
    logic         ebo, ez, eov;
    int           cyc;
    model(a, b, bin, ed, ebo, ez, eov);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(N));
    check("D", 32'(D), 32'(ed));
    check("b_out", 32'(b_out), 32'(ebo));
    check("zero", 32'(zero), 32'(ez));
    check("ovf", 32'(ovf), 32'(eov));
    if (hold_next) drive(8'hAA, 8'h01, 1'b0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ready", 32'(in_ready), 32'd0);
      check("stall_D", {31'd0, 1'b0} | 32'(D), 32'(ed));
      check("stall_flags", 32'({b_out, zero, ovf}), 32'({ebo, ez, eov}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (!hold_next) in_valid = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin, input int stall);
    drive(a, b, bin);
    accept();
    collect(a, b, bin, stall, 1'b0);
  endtask

  initial begin
    int seen;
    logic [N-1:0] ra, rb;
    logic         rbin;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    b_in      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_flags", 32'({b_out, zero, ovf}), 32'd0);

    op(8'h05, 8'h03, 1'b0, 0);
    op(8'h03, 8'h05, 1'b0, 1);
    op(8'h80, 8'h01, 1'b0, 0);
    op(8'h7F, 8'hFF, 1'b0, 2);
    op(8'h10, 8'h0F, 1'b1, 0);
    op(8'h00, 8'h00, 1'b1, 0);

    // Backpressure with a new request pending for the whole stall
    drive(8'h33, 8'h11, 1'b0);
    accept();
    collect(8'h33, 8'h11, 1'b0, 5, 1'b1);
    accept();
    collect(8'hAA, 8'h01, 1'b0, 0, 1'b0);

    // Reset in the 4th RUN cycle aborts the operation
    drive(8'h55, 8'h22, 1'b0);
    accept();
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("ready_during_rst", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_D", 32'(D), 32'd0);
    check("abort_flags", 32'({out_valid, b_out, zero, ovf}), 32'd0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    op(8'h20, 8'h01, 1'b0, 0);

    for (int k = 0; k < 30; k++) begin
      ra   = N'($urandom);
      rb   = N'($urandom);
      rbin = 1'($urandom);
      if (k == 0) rb = ra;
      op(ra, rb, rbin, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
